// File: rtl/mbinit_sb_tx_arbiter.sv
// Round-robin arbiter sharing the sideband TX channel between the REPAIRCLK TX-side and
// RX-side sub-FSMs; issues one transaction and tracks the encoder busy handshake.
module mbinit_sb_tx_arbiter #(
  parameter int unsigned SB_MSG_Width  = 4,
  parameter int unsigned DATA_W        = 3,
  parameter int unsigned BUSY_WAIT_MAX = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_en,
  input  logic [SB_MSG_Width-1:0] i_tx_msg,
  input  logic [DATA_W-1:0]       i_tx_data,
  input  logic                    i_tx_msg_valid,
  input  logic [SB_MSG_Width-1:0] i_rx_msg,
  input  logic [DATA_W-1:0]       i_rx_data,
  input  logic                    i_rx_msg_valid,
  input  logic                    i_sb_busy,
  output logic [SB_MSG_Width-1:0] o_sb_msg,
  output logic [DATA_W-1:0]       o_sb_data,
  output logic                    o_sb_msg_valid,
  output logic                    o_tx_done,
  output logic                    o_rx_done,
  output logic [1:0]              o_grant,
  output logic                    o_timeout
);

  localparam int unsigned CntW = $clog2(BUSY_WAIT_MAX + 1);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWaitBusy,
    StWaitFall
  } state_e;

  state_e                  state_q, state_d;
  logic                    busy_q;
  logic                    last_grant_q, last_grant_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic [CntW-1:0]         cnt_inc;
  logic [SB_MSG_Width-1:0] msg_q, msg_d;
  logic [DATA_W-1:0]       data_q, data_d;
  logic                    valid_q, valid_d;
  logic                    tx_done_q, tx_done_d;
  logic                    rx_done_q, rx_done_d;
  logic [1:0]              grant_q, grant_d;
  logic                    timeout_q, timeout_d;

  logic fall;
  logic tx_elig, rx_elig, pick_rx;

  assign fall    = busy_q & ~i_sb_busy;
  // A requester's valid is still high during its own done cycle; mask it there.
  assign tx_elig = i_tx_msg_valid & ~tx_done_q;
  assign rx_elig = i_rx_msg_valid & ~rx_done_q;
  assign pick_rx = rx_elig & (~tx_elig | ~last_grant_q);
  assign cnt_inc = cnt_q + CntW'(1);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    msg_d        = msg_q;
    data_d       = data_q;
    grant_d      = grant_q;
    valid_d      = 1'b0;
    tx_done_d    = 1'b0;
    rx_done_d    = 1'b0;
    timeout_d    = 1'b0;

    if (!i_en) begin
      state_d = StIdle;
      grant_d = 2'b00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!i_sb_busy && (tx_elig || rx_elig)) begin
            msg_d        = pick_rx ? i_rx_msg : i_tx_msg;
            data_d       = pick_rx ? i_rx_data : i_tx_data;
            grant_d      = pick_rx ? 2'b10 : 2'b01;
            last_grant_d = pick_rx;
            valid_d      = 1'b1;
            state_d      = StIssue;
          end
        end
        StIssue: begin
          if (i_sb_busy) begin
            state_d = StWaitFall;
          end else begin
            cnt_d   = '0;
            state_d = StWaitBusy;
          end
        end
        StWaitBusy: begin
          if (i_sb_busy) begin
            state_d = StWaitFall;
          end else if (cnt_inc == CntW'(BUSY_WAIT_MAX)) begin
            // Encoder never responded: drop ownership, request stays pending for retry.
            cnt_d     = cnt_inc;
            timeout_d = 1'b1;
            grant_d   = 2'b00;
            state_d   = StIdle;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        StWaitFall: begin
          if (fall) begin
            tx_done_d = grant_q[0];
            rx_done_d = grant_q[1];
            grant_d   = 2'b00;
            state_d   = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= StIdle;
      busy_q       <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      msg_q        <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      tx_done_q    <= 1'b0;
      rx_done_q    <= 1'b0;
      grant_q      <= 2'b00;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= i_sb_busy;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      msg_q        <= msg_d;
      data_q       <= data_d;
      valid_q      <= valid_d;
      tx_done_q    <= tx_done_d;
      rx_done_q    <= rx_done_d;
      grant_q      <= grant_d;
      timeout_q    <= timeout_d;
    end
  end

  assign o_sb_msg       = msg_q;
  assign o_sb_data      = data_q;
  assign o_sb_msg_valid = valid_q;
  assign o_tx_done      = tx_done_q;
  assign o_rx_done      = rx_done_q;
  assign o_grant        = grant_q;
  assign o_timeout      = timeout_q;

endmodule
